// File: rtl/alarm_pkg.sv
// Shared types and helpers for the multi-channel temperature alarm engine.
// Level encoding is shared by the channel slices and the top level.
package alarm_pkg;

  typedef enum logic [1:0] {
    LVL_NORMAL = 2'd0,
    LVL_WARN   = 2'd1,
    LVL_FIRE   = 2'd2
  } level_e;

  function automatic logic [31:0] sat_sub(
    input logic [31:0] a,
    input logic [31:0] b
  );
    return (a > b) ? (a - b) : 32'd0;
  endfunction

endpackage

// File: rtl/alarm_channel.sv
// One sensor channel: raw classification with hysteresis, persistence
// filter and the last accepted sample.
module alarm_channel
  import alarm_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int PERSIST = 4,
  parameter int HYST    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              accept_i,
  input  logic [DATA_W-1:0] sample_i,
  input  logic [DATA_W-1:0] warn_thresh_i,
  input  logic [DATA_W-1:0] fire_thresh_i,
  output level_e            level_o,
  output logic [DATA_W-1:0] last_o
);

  localparam int CNT_W = $clog2(PERSIST + 1);

  level_e            lvl_q, lvl_d;
  level_e            pend_q, pend_d;
  level_e            raw;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [DATA_W-1:0] last_q, last_d;
  logic [DATA_W-1:0] fire_lim, warn_lim;

  always_comb begin
    fire_lim = fire_thresh_i;
    warn_lim = warn_thresh_i;
    // Leaving a level needs the sample to drop HYST below its threshold.
    if (lvl_q == LVL_FIRE) begin
      fire_lim = DATA_W'(sat_sub(32'(fire_thresh_i), 32'(HYST)));
    end
    if (lvl_q != LVL_NORMAL) begin
      warn_lim = DATA_W'(sat_sub(32'(warn_thresh_i), 32'(HYST)));
    end
    raw = LVL_NORMAL;
    if (sample_i >= fire_lim) begin
      raw = LVL_FIRE;
    end else if (sample_i >= warn_lim) begin
      raw = LVL_WARN;
    end
  end

  always_comb begin
    lvl_d   = lvl_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    cnt_inc = cnt_q + CNT_W'(1);
    if (accept_i) begin
      last_d = sample_i;
      if (raw == lvl_q) begin
        cnt_d = '0;
      end else if (raw == pend_q) begin
        if (cnt_inc == CNT_W'(PERSIST)) begin
          lvl_d = raw;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end else begin
        pend_d = raw;
        if (PERSIST == 1) begin
          lvl_d = raw;
          cnt_d = '0;
        end else begin
          cnt_d = CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_q  <= LVL_NORMAL;
      pend_q <= LVL_NORMAL;
      cnt_q  <= '0;
      last_q <= '0;
    end else begin
      lvl_q  <= lvl_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      last_q <= last_d;
    end
  end

  assign level_o = lvl_q;
  assign last_o  = last_q;

endmodule

// File: rtl/temp_alarm_monitor.sv
// Multi-channel temperature alarm: per-channel levels, sticky fire latch,
// buzzer drive and argmax over the last stored samples.
module temp_alarm_monitor
  import alarm_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int DATA_W   = 8,
  parameter int PERSIST  = 4,
  parameter int HYST     = 2,
  parameter int BEEP_DIV = 50_000_000,
  parameter int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_valid,
  input  logic [CH_W-1:0]   sample_ch,
  input  logic [DATA_W-1:0] sample_data,
  input  logic [DATA_W-1:0] warn_thresh,
  input  logic [DATA_W-1:0] fire_thresh,
  input  logic              ack,
  output logic [NUM_CH-1:0] ch_warning,
  output logic [NUM_CH-1:0] ch_fire,
  output logic              any_warning,
  output logic              any_fire,
  output logic              fire_latched,
  output logic              buzzer,
  output logic [DATA_W-1:0] max_temp,
  output logic [CH_W-1:0]   max_ch
);

  localparam int BW = (BEEP_DIV > 1) ? $clog2(BEEP_DIV) : 1;

  level_e            lvl  [NUM_CH];
  logic [DATA_W-1:0] last [NUM_CH];

  // Tags >= NUM_CH match no slice and are dropped.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic acc;
    assign acc = sample_valid && (sample_ch == CH_W'(i));

    alarm_channel #(
      .DATA_W  (DATA_W),
      .PERSIST (PERSIST),
      .HYST    (HYST)
    ) u_ch (
      .clk           (clk),
      .rst_n         (rst_n),
      .accept_i      (acc),
      .sample_i      (sample_data),
      .warn_thresh_i (warn_thresh),
      .fire_thresh_i (fire_thresh),
      .level_o       (lvl[i]),
      .last_o        (last[i])
    );

    assign ch_warning[i] = (lvl[i] == LVL_WARN);
    assign ch_fire[i]    = (lvl[i] == LVL_FIRE);
  end

  assign any_warning = |ch_warning;
  assign any_fire    = |ch_fire;

  logic [DATA_W-1:0] max_temp_q, max_temp_d;
  logic [CH_W-1:0]   max_ch_q, max_ch_d;

  always_comb begin
    max_temp_d = last[0];
    max_ch_d   = '0;
    for (int i = 1; i < NUM_CH; i++) begin
      if (last[i] > max_temp_d) begin
        max_temp_d = last[i];
        max_ch_d   = CH_W'(i);
      end
    end
  end

  logic fire_lat_q, fire_lat_d;

  always_comb begin
    fire_lat_d = fire_lat_q;
    if (any_fire) begin
      fire_lat_d = 1'b1;
    end else if (ack) begin
      fire_lat_d = 1'b0;
    end
  end

  logic          buz_q, buz_d;
  logic [BW-1:0] beep_cnt_q, beep_cnt_d;
  logic          beep_ph_q, beep_ph_d;

  // Phase 0 is the high half of the beep, so each enable starts high.
  always_comb begin
    buz_d      = 1'b0;
    beep_cnt_d = '0;
    beep_ph_d  = 1'b0;
    if (fire_lat_q) begin
      buz_d = 1'b1;
    end else if (any_warning) begin
      buz_d     = ~beep_ph_q;
      beep_ph_d = beep_ph_q;
      if (beep_cnt_q == BW'(BEEP_DIV - 1)) begin
        beep_ph_d = ~beep_ph_q;
      end else begin
        beep_cnt_d = beep_cnt_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_temp_q <= '0;
      max_ch_q   <= '0;
      fire_lat_q <= 1'b0;
      buz_q      <= 1'b0;
      beep_cnt_q <= '0;
      beep_ph_q  <= 1'b0;
    end else begin
      max_temp_q <= max_temp_d;
      max_ch_q   <= max_ch_d;
      fire_lat_q <= fire_lat_d;
      buz_q      <= buz_d;
      beep_cnt_q <= beep_cnt_d;
      beep_ph_q  <= beep_ph_d;
    end
  end

  assign fire_latched = fire_lat_q;
  assign buzzer       = buz_q;
  assign max_temp     = max_temp_q;
  assign max_ch       = max_ch_q;

endmodule
